// File: rtl/nco_core.sv
// Phase-accumulator NCO with a byte-wide waveform LUT that is loaded while idle.
// The step is reloaded on phase wrap only, so frequency changes are phase-continuous.
module nco_core #(
    parameter int PHASE_W = 24,
    parameter int STEP_W  = 14,
    parameter int LUT_AW  = 8,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               nco_we_i,
    input  logic [DATA_W-1:0]  nco_data_i,
    input  logic [STEP_W-1:0]  nco_freq_step_i,
    output logic [DATA_W-1:0]  sample_o,
    output logic               sample_valid_o,
    output logic               load_done_o,
    output logic               wr_overrun_o,
    output logic [PHASE_W-1:0] phase_o
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [LUT_AW-1:0]   wr_addr_q, wr_addr_d;
    logic                valid_q, valid_d;
    logic                load_done_q, load_done_d;
    logic                overrun_q, overrun_d;
    logic                primed_q, primed_d;

    logic [DATA_W-1:0]   lut_mem [2**LUT_AW];
    logic [DATA_W-1:0]   lut_rd_q;
    logic [LUT_AW-1:0]   rd_addr;
    logic                lut_we;
    logic                rd_en;
    logic [PHASE_W:0]    phase_sum;

    assign rd_addr   = phase_q[PHASE_W-1 -: LUT_AW];
    assign phase_sum = {1'b0, phase_q} + {{(PHASE_W + 1 - STEP_W){1'b0}}, step_q};

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        step_d      = step_q;
        wr_addr_d   = wr_addr_q;
        valid_d     = 1'b0;
        load_done_d = 1'b0;
        overrun_d   = 1'b0;
        primed_d    = primed_q;
        lut_we      = 1'b0;
        rd_en       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                phase_d = '0;
                step_d  = nco_freq_step_i;
                if (en_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                phase_d  = phase_sum[PHASE_W-1:0];
                // Carry out of the add marks the wrap point where a new step may be taken.
                if (phase_sum[PHASE_W]) begin
                    step_d = nco_freq_step_i;
                end
                valid_d  = 1'b1;
                rd_en    = 1'b1;
                primed_d = 1'b1;
                if (!en_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (nco_we_i) begin
            if (en_i || (state_q == S_RUN)) begin
                overrun_d = 1'b1;
            end else begin
                lut_we      = 1'b1;
                wr_addr_d   = wr_addr_q + 1'b1;
                load_done_d = (wr_addr_q == {LUT_AW{1'b1}});
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            step_q      <= '0;
            wr_addr_q   <= '0;
            valid_q     <= 1'b0;
            load_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            primed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            step_q      <= step_d;
            wr_addr_q   <= wr_addr_d;
            valid_q     <= valid_d;
            load_done_q <= load_done_d;
            overrun_q   <= overrun_d;
            primed_q    <= primed_d;
        end
    end

    // Reset-free memory so it maps onto block RAM; the read register holds when idle.
    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut_mem[wr_addr_q] <= nco_data_i;
        end
        if (rd_en) begin
            lut_rd_q <= lut_mem[rd_addr];
        end
    end

    // Until the first read after reset the RAM register is meaningless, so present zero.
    assign sample_o       = primed_q ? lut_rd_q : '0;
    assign sample_valid_o = valid_q;
    assign load_done_o    = load_done_q;
    assign wr_overrun_o   = overrun_q;
    assign phase_o        = phase_q;

endmodule

// File: tb/tb_nco_core.sv
// Directed bench for nco_core: reset, LUT load, ramp runs, wrap-timed step change,
// overrun handling and asynchronous reset during run and load.
`timescale 1ns/1ps
module tb_nco_core;

    logic        clk;
    logic        rst_n;
    logic        en_i;
    logic        nco_we_i;
    logic [7:0]  nco_data_i;
    logic [13:0] nco_freq_step_i;
    logic [7:0]  sample_o;
    logic        sample_valid_o;
    logic        load_done_o;
    logic        wr_overrun_o;
    logic [23:0] phase_o;

    int n_vec = 0;
    int n_err = 0;

    nco_core dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_i            (en_i),
        .nco_we_i        (nco_we_i),
        .nco_data_i      (nco_data_i),
        .nco_freq_step_i (nco_freq_step_i),
        .sample_o        (sample_o),
        .sample_valid_o  (sample_valid_o),
        .load_done_o     (load_done_o),
        .wr_overrun_o    (wr_overrun_o),
        .phase_o         (phase_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        we;
        logic [7:0]  data;
        logic [13:0] step;
        logic [7:0]  sample;
        logic        valid;
        logic        ld;
        logic        ovr;
        logic [23:0] phase;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bytes(input int n, input int last_idx, input logic [7:0] xv);
        for (int i = 0; i < n; i++) begin
            nco_we_i   = 1'b1;
            nco_data_i = 8'(i) ^ xv;
            step_clk();
            chk($sformatf("load_done[%0d]", i), 32'(load_done_o), 32'(i == last_idx));
        end
        nco_we_i = 1'b0;
    endtask

    // Closed-form phase after k run edges with step 0x3FFF, switching to 0x1000 at the first wrap.
    function automatic logic [23:0] phase4(input int k);
        if (k <= 1024) return 24'(k * 32'h3FFF);
        return 24'(32'h3BFF + (k - 1025) * 32'h1000);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] ph;

        //                 en    we    data   step      sample valid ld    ovr   phase
        tbl[0]  = '{1'b1, 1'b1, 8'hAA, 14'h0040, 8'h00, 1'b0, 1'b0, 1'b1, 24'h000000};
        tbl[1]  = '{1'b1, 1'b1, 8'hAA, 14'h0040, 8'h00, 1'b1, 1'b0, 1'b1, 24'h000040};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 14'h0040, 8'h00, 1'b1, 1'b0, 1'b0, 24'h000080};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 14'h0040, 8'h00, 1'b1, 1'b0, 1'b0, 24'h0000C0};
        tbl[4]  = '{1'b0, 1'b1, 8'h5A, 14'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 14'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 14'h0000, 8'h5A, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 14'h0000, 8'h5A, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[8]  = '{1'b1, 1'b1, 8'hAA, 14'h0000, 8'h5A, 1'b1, 1'b0, 1'b1, 24'h000000};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 14'h0000, 8'h5A, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 14'h0000, 8'h5A, 1'b0, 1'b0, 1'b0, 24'h000000};

        rst_n = 1'b0;
        en_i = 1'b0;
        nco_we_i = 1'b0;
        nco_data_i = 8'h00;
        nco_freq_step_i = 14'h0000;

        // Reset state
        #1;
        chk("rst_sample", 32'(sample_o), 32'h0);
        chk("rst_valid", 32'(sample_valid_o), 32'h0);
        chk("rst_ld", 32'(load_done_o), 32'h0);
        chk("rst_ovr", 32'(wr_overrun_o), 32'h0);
        chk("rst_phase", 32'(phase_o), 32'h0);
        repeat (3) step_clk();
        rst_n = 1'b1;
        step_clk();

        // Ramp load, load_done only after the last byte
        load_bytes(256, 255, 8'h00);
        step_clk();
        chk("ld_after_load", 32'(load_done_o), 32'h0);

        // Step 0x100: top byte advances every 256 clocks
        nco_freq_step_i = 14'h0100;
        en_i = 1'b1;
        step_clk();
        chk("t3_valid_n", 32'(sample_valid_o), 32'h0);
        chk("t3_phase_n", 32'(phase_o), 32'h0);
        for (int k = 1; k <= 513; k++) begin
            step_clk();
            chk($sformatf("t3_sample[%0d]", k), 32'(sample_o), ((k - 1) * 256) >> 16);
            chk($sformatf("t3_phase[%0d]", k), 32'(phase_o), k * 256);
            chk($sformatf("t3_valid[%0d]", k), 32'(sample_valid_o), 32'h1);
        end
        en_i = 1'b0;
        step_clk();
        chk("stop_m_valid", 32'(sample_valid_o), 32'h1);
        chk("stop_m_sample", 32'(sample_o), 32'h2);
        chk("stop_m_phase", 32'(phase_o), 514 * 256);
        step_clk();
        chk("stop_m1_valid", 32'(sample_valid_o), 32'h0);
        chk("stop_m1_phase", 32'(phase_o), 32'h0);
        chk("stop_m1_sample", 32'(sample_o), 32'h2);

        // Step 0x3FFF, new step 0x1000 presented early but taken only at wrap
        nco_freq_step_i = 14'h3FFF;
        en_i = 1'b1;
        step_clk();
        chk("t4_phase_n", 32'(phase_o), 32'h0);
        for (int k = 1; k <= 1030; k++) begin
            step_clk();
            ph = (k == 1) ? 24'h0 : phase4(k - 1);
            chk($sformatf("t4_phase[%0d]", k), 32'(phase_o), 32'(phase4(k)));
            chk($sformatf("t4_sample[%0d]", k), 32'(sample_o), 32'(ph[23:16]));
            if (k == 10) nco_freq_step_i = 14'h1000;
        end
        en_i = 1'b0;
        nco_freq_step_i = 14'h0000;
        step_clk();
        step_clk();
        chk("t4_stop_valid", 32'(sample_valid_o), 32'h0);

        // Table: overrun while running, LUT[0] untouched, idle write at wr_addr 0, step=0
        for (int i = 0; i < 11; i++) begin
            en_i = tbl[i].en;
            nco_we_i = tbl[i].we;
            nco_data_i = tbl[i].data;
            nco_freq_step_i = tbl[i].step;
            step_clk();
            chk($sformatf("tbl%0d_sample", i), 32'(sample_o), 32'(tbl[i].sample));
            chk($sformatf("tbl%0d_valid", i), 32'(sample_valid_o), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_ld", i), 32'(load_done_o), 32'(tbl[i].ld));
            chk($sformatf("tbl%0d_ovr", i), 32'(wr_overrun_o), 32'(tbl[i].ovr));
            chk($sformatf("tbl%0d_phase", i), 32'(phase_o), 32'(tbl[i].phase));
        end
        nco_we_i = 1'b0;

        // Asynchronous reset mid-run with an overrun pulse live
        nco_freq_step_i = 14'h3FFF;
        en_i = 1'b1;
        repeat (5) step_clk();
        nco_we_i = 1'b1;
        step_clk();
        chk("mr_ovr_pre", 32'(wr_overrun_o), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_sample", 32'(sample_o), 32'h0);
        chk("mr_valid", 32'(sample_valid_o), 32'h0);
        chk("mr_ovr", 32'(wr_overrun_o), 32'h0);
        chk("mr_phase", 32'(phase_o), 32'h0);
        en_i = 1'b0;
        nco_we_i = 1'b0;
        step_clk();
        rst_n = 1'b1;
        step_clk();

        // Reset mid-load, then a full load must restart from address 0
        load_bytes(100, -1, 8'h00);
        nco_we_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ml_ld", 32'(load_done_o), 32'h0);
        chk("ml_phase", 32'(phase_o), 32'h0);
        nco_we_i = 1'b0;
        step_clk();
        rst_n = 1'b1;
        step_clk();
        load_bytes(256, 255, 8'hFF);
        nco_freq_step_i = 14'h0000;
        en_i = 1'b1;
        step_clk();
        step_clk();
        chk("ml_lut0", 32'(sample_o), 32'hFF);
        chk("ml_valid", 32'(sample_valid_o), 32'h1);
        en_i = 1'b0;
        step_clk();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
